tlul_socket_1n_dec: RTL and testbench



---
 rtl/tl_main_pkg.sv | 53 +++++
 rtl/tlul_pkg.sv | 46 ++++
 rtl/tlul_err_resp.sv | 74 +++++++
 rtl/tlul_socket_1n_dec.sv | 102 ++++++++++
 tb/tb_tlul_socket_1n_dec.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_main_pkg.sv
// ---------------------------------------------------------------------------
// tl_main_pkg : main crossbar device map (address table and device indices).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tl_main_pkg;

  localparam int unsigned NumDevMain = 8;

  localparam logic [31:0] ADDR_SPACE_DCCM  = 32'h1000_0000;
  localparam logic [31:0] ADDR_SPACE_UART  = 32'h4000_0000;
  localparam logic [31:0] ADDR_SPACE_GPIO  = 32'h4001_0000;
  localparam logic [31:0] ADDR_SPACE_SPI   = 32'h4002_0000;
  localparam logic [31:0] ADDR_SPACE_TIMER = 32'h4008_0000;
  localparam logic [31:0] ADDR_SPACE_PLIC  = 32'h4800_0000;
  localparam logic [31:0] ADDR_SPACE_ROM   = 32'h0000_8000;
  localparam logic [31:0] ADDR_SPACE_ICCM  = 32'h0010_0000;

  localparam logic [31:0] ADDR_MASK_DCCM   = 32'h0000_FFFF;
  localparam logic [31:0] ADDR_MASK_UART   = 32'h0000_0FFF;
  localparam logic [31:0] ADDR_MASK_GPIO   = 32'h0000_0FFF;
  localparam logic [31:0] ADDR_MASK_SPI    = 32'h0000_0FFF;
  localparam logic [31:0] ADDR_MASK_TIMER  = 32'h0000_0FFF;
  localparam logic [31:0] ADDR_MASK_PLIC   = 32'h0000_0FFF;
  localparam logic [31:0] ADDR_MASK_ROM    = 32'h0000_3FFF;
  localparam logic [31:0] ADDR_MASK_ICCM   = 32'h0000_FFFF;

  typedef enum int unsigned {
    TlDccm  = 0,
    TlUart  = 1,
    TlGpio  = 2,
    TlSpi   = 3,
    TlTimer = 4,
    TlPlic  = 5,
    TlRom   = 6,
    TlIccm  = 7
  } tl_device_e;

  // Concatenation is MSB-first, so the last entry lands at index 0.
  localparam logic [NumDevMain-1:0][31:0] DefAddrBase = {
    ADDR_SPACE_ICCM, ADDR_SPACE_ROM, ADDR_SPACE_PLIC, ADDR_SPACE_TIMER,
    ADDR_SPACE_SPI, ADDR_SPACE_GPIO, ADDR_SPACE_UART, ADDR_SPACE_DCCM
  };

  localparam logic [NumDevMain-1:0][31:0] DefAddrMask = {
    ADDR_MASK_ICCM, ADDR_MASK_ROM, ADDR_MASK_PLIC, ADDR_MASK_TIMER,
    ADDR_MASK_SPI, ADDR_MASK_GPIO, ADDR_MASK_UART, ADDR_MASK_DCCM
  };

endpackage

`default_nettype wire

// File: rtl/tlul_pkg.sv
// ---------------------------------------------------------------------------
// tlul_pkg : TL-UL channel structs and opcode enums shared by the crossbar.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

`default_nettype wire

// File: rtl/tlul_err_resp.sv
// ---------------------------------------------------------------------------
// tlul_err_resp : single-entry TL-UL error responder for unmapped requests.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tlul_err_resp
  import tlul_pkg::*;
#(
  parameter logic [31:0] ErrData = 32'hFFFF_FFFF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       a_valid_i,
  input  tl_a_op_e   a_opcode_i,
  input  logic [7:0] a_source_i,
  input  logic [1:0] a_size_i,
  input  logic       d_ready_i,
  output tl_d2h_t    rsp_o
);

  typedef enum logic {
    ErrIdle = 1'b0,
    ErrResp = 1'b1
  } err_state_e;

  err_state_e state, state_d;
  logic [7:0] source;
  logic [1:0] size;
  logic       is_get;
  logic       accept;

  assign accept = a_valid_i & (state == ErrIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ErrIdle;
      source <= '0;
      size   <= '0;
      is_get <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        source <= a_source_i;
        size   <= a_size_i;
        is_get <= (a_opcode_i == Get);
      end
    end
  end

  always_comb begin
    state_d = state;
    rsp_o   = '0;
    case (state)
      ErrIdle: begin
        rsp_o.a_ready = 1'b1;
        if (a_valid_i) state_d = ErrResp;
      end
      ErrResp: begin
        rsp_o.d_valid  = 1'b1;
        rsp_o.d_error  = 1'b1;
        rsp_o.d_opcode = is_get ? AccessAckData : AccessAck;
        rsp_o.d_data   = is_get ? ErrData : 32'h0;
        rsp_o.d_source = source;
        rsp_o.d_size   = size;
        if (d_ready_i) state_d = ErrIdle;
      end
      default: state_d = ErrIdle;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/tlul_socket_1n_dec.sv
// ---------------------------------------------------------------------------
// tlul_socket_1n_dec : TL-UL 1:N demux with address decode, in-order tracking
// and an integrated error responder for unmapped addresses.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tlul_socket_1n_dec
  import tlul_pkg::*;
  import tl_main_pkg::*;
#(
  parameter int unsigned          N              = NumDevMain,
  parameter int unsigned          MaxOutstanding = 4,
  parameter logic [N-1:0][31:0]   AddrBase       = DefAddrBase,
  parameter logic [N-1:0][31:0]   AddrMask       = DefAddrMask,
  parameter logic [31:0]          ErrData        = 32'hFFFF_FFFF
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_h_i,
  output tl_d2h_t tl_h_o,
  output tl_h2d_t tl_d_o [N],
  input  tl_d2h_t tl_d_i [N]
);

  localparam int unsigned    CntW   = $clog2(MaxOutstanding + 1);
  localparam int unsigned    SelW   = $clog2(N + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
  localparam logic [SelW-1:0] ErrSel = SelW'(N);

  logic [SelW-1:0] sel;
  logic [SelW-1:0] sel_q;
  logic [CntW-1:0] cnt;
  logic            go;
  logic            accept;
  logic            respond;
  tl_d2h_t         err_rsp;
  tl_d2h_t         tgt_rsp [N+1];

  // Descending scan so the lowest-index hit is the one left in sel.
  always_comb begin
    sel = ErrSel;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if ((tl_h_i.a_address & ~AddrMask[i]) == AddrBase[i]) sel = SelW'(i);
    end
  end

  // A new target is only allowed once the previous one has fully drained.
  assign go = tl_h_i.a_valid &
              ((cnt == '0) | ((sel == sel_q) & (cnt < MaxCnt)));

  always_comb begin
    for (int i = 0; i < int'(N); i++) tgt_rsp[i] = tl_d_i[i];
    tgt_rsp[N] = err_rsp;
  end

  always_comb begin
    tl_h_o         = tgt_rsp[sel_q];
    tl_h_o.d_valid = (cnt != '0) & tgt_rsp[sel_q].d_valid;
    tl_h_o.a_ready = go & tgt_rsp[sel].a_ready;
  end

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      tl_d_o[i]         = tl_h_i;
      tl_d_o[i].a_valid = go & (sel == SelW'(i));
      tl_d_o[i].d_ready = tl_h_i.d_ready & (cnt != '0) & (sel_q == SelW'(i));
    end
  end

  assign accept  = tl_h_i.a_valid & tl_h_o.a_ready;
  assign respond = tl_h_o.d_valid & tl_h_i.d_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt   <= '0;
      sel_q <= '0;
    end else begin
      if (accept) sel_q <= sel;
      if (accept & ~respond) begin
        cnt <= cnt + CntW'(1);
      end else if (~accept & respond) begin
        cnt <= cnt - CntW'(1);
      end
    end
  end

  tlul_err_resp #(
    .ErrData (ErrData)
  ) u_err_resp (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .a_valid_i  (go & (sel == ErrSel)),
    .a_opcode_i (tl_h_i.a_opcode),
    .a_source_i (tl_h_i.a_source),
    .a_size_i   (tl_h_i.a_size),
    .d_ready_i  (tl_h_i.d_ready & (cnt != '0) & (sel_q == ErrSel)),
    .rsp_o      (err_rsp)
  );

endmodule

`default_nettype wire

// File: tb/tb_tlul_socket_1n_dec.sv
// ---------------------------------------------------------------------------
// tb_tlul_socket_1n_dec : directed bench with an outstanding-queue model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tlul_socket_1n_dec;
  import tlul_pkg::*;
  import tl_main_pkg::*;

  localparam int N    = 8;
  localparam int MAXO = 4;

  logic    clk    = 1'b0;
  logic    rst_ni = 1'b0;
  tl_h2d_t h_i;
  tl_d2h_t h_o;
  tl_h2d_t d_o [N];
  tl_d2h_t d_i [N];

  tlul_socket_1n_dec #(
    .N              (N),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .tl_h_i (h_i),
    .tl_h_o (h_o),
    .tl_d_o (d_o),
    .tl_d_i (d_i)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of accepted-but-unanswered requests, oldest first.
  typedef struct {
    int         tgt;
    logic [7:0] src;
    logic [1:0] size;
    bit         is_get;
  } ent_t;
  ent_t q[$];

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & ~DefAddrMask[i]) == DefAddrBase[i]) return i;
    return N;
  endfunction

  function automatic bit m_gate();
    if (q.size() == 0) return 1'b1;
    return (q[0].tgt == decode(h_i.a_address)) && (q.size() < MAXO);
  endfunction

  function automatic bit err_busy();
    foreach (q[k]) if (q[k].tgt == N) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_a_ready();
    int t;
    t = decode(h_i.a_address);
    if (!h_i.a_valid || !m_gate()) return 1'b0;
    return (t == N) ? !err_busy() : d_i[t].a_ready;
  endfunction

  function automatic bit m_d_valid();
    if (q.size() == 0) return 1'b0;
    return (q[0].tgt == N) ? 1'b1 : d_i[q[0].tgt].d_valid;
  endfunction

  always @(negedge clk) begin
    chk("a_ready", h_o.a_ready, m_a_ready());
    chk("d_valid", h_o.d_valid, m_d_valid());
    for (int i = 0; i < N; i++) begin
      chk($sformatf("dev%0d_a_valid", i), d_o[i].a_valid,
          h_i.a_valid && m_gate() && (decode(h_i.a_address) == i));
      chk($sformatf("dev%0d_d_ready", i), d_o[i].d_ready,
          h_i.d_ready && (q.size() > 0) && (q[0].tgt == i));
      chk($sformatf("dev%0d_addr", i), d_o[i].a_address, h_i.a_address);
    end
    if (m_d_valid()) begin
      if (q[0].tgt == N) begin
        chk("err_d_error", h_o.d_error, 1);
        chk("err_d_opcode", h_o.d_opcode, q[0].is_get ? AccessAckData : AccessAck);
        chk("err_d_data", h_o.d_data, q[0].is_get ? 32'hFFFF_FFFF : 32'h0);
        chk("err_d_source", h_o.d_source, q[0].src);
        chk("err_d_size", h_o.d_size, q[0].size);
      end else begin
        chk("dev_d_data", h_o.d_data, d_i[q[0].tgt].d_data);
        chk("dev_d_source", h_o.d_source, d_i[q[0].tgt].d_source);
        chk("dev_d_opcode", h_o.d_opcode, d_i[q[0].tgt].d_opcode);
        chk("dev_d_error", h_o.d_error, d_i[q[0].tgt].d_error);
      end
    end
  end

  always @(posedge clk or negedge rst_ni) begin
    bit   acc;
    bit   rsp;
    ent_t e;
    if (!rst_ni) begin
      q.delete();
    end else begin
      acc      = h_i.a_valid && m_a_ready();
      rsp      = m_d_valid() && h_i.d_ready;
      e.tgt    = decode(h_i.a_address);
      e.src    = h_i.a_source;
      e.size   = h_i.a_size;
      e.is_get = (h_i.a_opcode == Get);
      if (rsp) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic req(input tl_a_op_e op, input logic [31:0] addr,
                     input logic [7:0] src, input logic [1:0] size);
    h_i.a_valid   = 1'b1;
    h_i.a_opcode  = op;
    h_i.a_address = addr;
    h_i.a_source  = src;
    h_i.a_size    = size;
  endtask

  task automatic dev_rsp(input int i, input bit v, input logic [31:0] data,
                         input logic [7:0] src, input tl_d_op_e op);
    d_i[i].d_valid  = v;
    d_i[i].d_data   = data;
    d_i[i].d_source = src;
    d_i[i].d_opcode = op;
    d_i[i].d_size   = 2'd2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    h_i         = '0;
    h_i.d_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      d_i[i]         = '0;
      d_i[i].a_ready = 1'b1;
    end

    // Reset state
    step();
    neg();
    chk("rst h_d_valid", h_o.d_valid, 0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst dev%0d d_ready", i), d_o[i].d_ready, 0);
      chk($sformatf("rst dev%0d a_valid", i), d_o[i].a_valid, 0);
    end
    step();
    rst_ni = 1'b1;
    step();

    // Get to DCCM, response two cycles after accept
    req(Get, 32'h1000_0040, 8'd1, 2'd2);
    neg();
    chk("s1 dccm a_valid", d_o[0].a_valid, 1);
    chk("s1 a_ready", h_o.a_ready, 1);
    step();
    h_i.a_valid = 1'b0;
    neg();
    chk("s1 a_valid one cycle", d_o[0].a_valid, 0);
    chk("s1 no early d_valid", h_o.d_valid, 0);
    step();
    dev_rsp(0, 1'b1, 32'h1234_5678, 8'd1, AccessAckData);
    neg();
    chk("s1 d_valid", h_o.d_valid, 1);
    chk("s1 d_data", h_o.d_data, 32'h1234_5678);
    chk("s1 d_source", h_o.d_source, 1);
    step();
    dev_rsp(0, 1'b0, 32'h0, 8'd0, AccessAck);
    neg();
    chk("s1 d_valid cleared", h_o.d_valid, 0);
    step();

    // Four Puts to UART fill the tracker, fifth waits for a response
    req(PutFullData, 32'h4000_0004, 8'd2, 2'd2);
    for (int k = 0; k < 4; k++) begin
      neg();
      chk("s2 put accepted", h_o.a_ready, 1);
      step();
    end
    neg();
    chk("s2 fifth stalled", h_o.a_ready, 0);
    step();
    dev_rsp(1, 1'b1, 32'h0, 8'd2, AccessAck);
    neg();
    chk("s2 stalled at rsp", h_o.a_ready, 0);
    chk("s2 rsp d_valid", h_o.d_valid, 1);
    step();
    neg();
    chk("s2 fifth accepted", h_o.a_ready, 1);
    step();
    h_i.a_valid = 1'b0;
    repeat (3) step();
    neg();
    chk("s2 drained no d_valid", h_o.d_valid, 0);
    chk("s2 drained d_ready", d_o[1].d_ready, 0);
    step();
    dev_rsp(1, 1'b0, 32'h0, 8'd0, AccessAck);

    // UART outstanding blocks a GPIO request until it returns
    req(Get, 32'h4000_0010, 8'd5, 2'd2);
    neg();
    chk("s3 uart accepted", h_o.a_ready, 1);
    step();
    req(Get, 32'h4001_0000, 8'd6, 2'd2);
    repeat (2) begin
      neg();
      chk("s3 gpio stalled", h_o.a_ready, 0);
      chk("s3 gpio a_valid", d_o[2].a_valid, 0);
      step();
    end
    dev_rsp(1, 1'b1, 32'hAAAA_0001, 8'd5, AccessAckData);
    neg();
    chk("s3 gpio still stalled", h_o.a_ready, 0);
    chk("s3 uart d_data", h_o.d_data, 32'hAAAA_0001);
    chk("s3 uart d_source", h_o.d_source, 5);
    step();
    dev_rsp(1, 1'b0, 32'h0, 8'd0, AccessAck);
    neg();
    chk("s3 gpio issued", d_o[2].a_valid, 1);
    chk("s3 gpio a_ready", h_o.a_ready, 1);
    step();
    h_i.a_valid = 1'b0;
    neg();
    chk("s3 no stale d_valid", h_o.d_valid, 0);
    step();
    dev_rsp(2, 1'b1, 32'hBBBB_0002, 8'd6, AccessAckData);
    neg();
    chk("s3 gpio d_data", h_o.d_data, 32'hBBBB_0002);
    step();
    dev_rsp(2, 1'b0, 32'h0, 8'd0, AccessAck);

    // Unmapped Get: error AccessAckData held while stalled
    req(Get, 32'hDEAD_0000, 8'd3, 2'd2);
    neg();
    chk("s4 a_ready", h_o.a_ready, 1);
    for (int i = 0; i < N; i++)
      chk($sformatf("s4 dev%0d a_valid", i), d_o[i].a_valid, 0);
    step();
    h_i.a_valid = 1'b0;
    h_i.d_ready = 1'b0;
    repeat (3) begin
      neg();
      chk("s4 d_valid", h_o.d_valid, 1);
      chk("s4 d_error", h_o.d_error, 1);
      chk("s4 d_opcode", h_o.d_opcode, AccessAckData);
      chk("s4 d_data", h_o.d_data, 32'hFFFF_FFFF);
      chk("s4 d_source", h_o.d_source, 3);
      chk("s4 d_size", h_o.d_size, 2);
      step();
    end
    h_i.d_ready = 1'b1;
    neg();
    chk("s4 d_valid at handshake", h_o.d_valid, 1);
    step();
    neg();
    chk("s4 d_valid cleared", h_o.d_valid, 0);
    step();

    // Unmapped Put: error AccessAck, no device request
    req(PutFullData, 32'hDEAD_1000, 8'd7, 2'd2);
    neg();
    chk("s5 a_ready", h_o.a_ready, 1);
    for (int i = 0; i < N; i++)
      chk($sformatf("s5 dev%0d a_valid", i), d_o[i].a_valid, 0);
    step();
    h_i.a_valid = 1'b0;
    neg();
    chk("s5 d_valid", h_o.d_valid, 1);
    chk("s5 d_opcode", h_o.d_opcode, AccessAck);
    chk("s5 d_error", h_o.d_error, 1);
    chk("s5 d_data", h_o.d_data, 32'h0);
    chk("s5 d_source", h_o.d_source, 7);
    step();
    neg();
    chk("s5 d_valid cleared", h_o.d_valid, 0);
    step();

    // Reset with two UART requests outstanding
    req(Get, 32'h4000_0020, 8'd8, 2'd2);
    neg();
    chk("s6 first accepted", h_o.a_ready, 1);
    step();
    neg();
    chk("s6 second accepted", h_o.a_ready, 1);
    step();
    h_i.a_valid = 1'b0;
    rst_ni = 1'b0;
    neg();
    chk("s6 reset d_valid", h_o.d_valid, 0);
    step();
    rst_ni = 1'b1;
    dev_rsp(1, 1'b1, 32'hCCCC_0003, 8'd8, AccessAckData);
    neg();
    chk("s6 late rsp dropped", h_o.d_valid, 0);
    chk("s6 late d_ready", d_o[1].d_ready, 0);
    step();
    req(Get, 32'h1000_0000, 8'd9, 2'd2);
    neg();
    chk("s6 new req accepted", h_o.a_ready, 1);
    step();
    h_i.a_valid = 1'b0;
    dev_rsp(1, 1'b0, 32'h0, 8'd0, AccessAck);
    dev_rsp(0, 1'b1, 32'h5555_0004, 8'd9, AccessAckData);
    neg();
    chk("s6 dccm d_data", h_o.d_data, 32'h5555_0004);
    step();
    dev_rsp(0, 1'b0, 32'h0, 8'd0, AccessAck);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
